// File: rtl/snake_body_engine.sv
// Snake body engine: keeps the segment list, moves/grows the snake one cell per step
// and streams the pixel writes needed to redraw the changed cells.
module snake_body_engine #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CELL    = 10,
    parameter int unsigned XSCREEN = 160,
    parameter int unsigned YSCREEN = 120,
    parameter int unsigned X0      = 80,
    parameter int unsigned Y0      = 60
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic                         step,
    input  logic [1:0]                   dir,
    input  logic                         grow,
    output logic                         busy,
    output logic                         done,
    output logic                         plot,
    output logic [7:0]                   x_out,
    output logic [6:0]                   y_out,
    output logic                         erase,
    output logic [7:0]                   head_x,
    output logic [6:0]                   head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         hit_wall,
    output logic                         hit_self
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_UP    = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_DRAW_ALL, S_CHECK, S_ERASE_TAIL, S_SHIFT, S_DRAW_HEAD, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    seg_x_q [MAX_LEN];
    logic [7:0]    seg_x_d [MAX_LEN];
    logic [6:0]    seg_y_q [MAX_LEN];
    logic [6:0]    seg_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    dir_q, dir_d;
    logic          grow_q, grow_d;
    logic          ready_q, ready_d;
    logic [7:0]    cx_q, cx_d;
    logic [6:0]    cy_q, cy_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          hit_self_q, hit_self_d;
    logic          hit_wall_q, hit_wall_d;
    logic          plot_q, plot_d;
    logic          erase_q, erase_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [7:0]    nh_x_c;
    logic [6:0]    nh_y_c;
    logic          wall_c, self_c, cell_end_c;
    logic [7:0]    cell_cx_c;
    logic [6:0]    cell_cy_c;
    logic [LW-1:0] lim_c;
    logic [IW-1:0] pix_idx_c;

    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        dir_d      = dir_q;
        grow_d     = grow_q;
        ready_d    = ready_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        idx_d      = idx_q;
        hit_self_d = hit_self_q;
        hit_wall_d = 1'b0;

        // Candidate head and wall test for the current direction
        nh_x_c = seg_x_q[0];
        nh_y_c = seg_y_q[0];
        wall_c = 1'b0;
        case (dir_q)
            D_RIGHT: begin
                wall_c = (seg_x_q[0] == 8'(XSCREEN - CELL));
                nh_x_c = seg_x_q[0] + 8'(CELL);
            end
            D_DOWN: begin
                wall_c = (seg_y_q[0] == 7'(YSCREEN - CELL));
                nh_y_c = seg_y_q[0] + 7'(CELL);
            end
            D_UP: begin
                wall_c = (seg_y_q[0] == 7'd0);
                nh_y_c = seg_y_q[0] - 7'(CELL);
            end
            default: begin
                wall_c = (seg_x_q[0] == 8'd0);
                nh_x_c = seg_x_q[0] - 8'(CELL);
            end
        endcase

        // The tail cell is vacated unless this move grows the snake
        lim_c  = grow_q ? len_q : len_q - LW'(1);
        self_c = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((LW'(i) < lim_c) && (seg_x_q[i] == nh_x_c) && (seg_y_q[i] == nh_y_c))
                self_c = 1'b1;
        end

        cell_end_c = (cx_q == 8'(CELL - 1)) && (cy_q == 7'(CELL - 1));
        if (cx_q == 8'(CELL - 1)) begin
            cell_cx_c = 8'd0;
            cell_cy_c = (cy_q == 7'(CELL - 1)) ? 7'd0 : cy_q + 7'd1;
        end else begin
            cell_cx_c = cx_q + 8'd1;
            cell_cy_c = cy_q;
        end

        case (state_q)
            S_IDLE: begin
                if (init) begin
                    seg_x_d[0] = 8'(X0);
                    seg_y_d[0] = 7'(Y0);
                    len_d      = LW'(1);
                    dir_d      = D_RIGHT;
                    hit_self_d = 1'b0;
                    ready_d    = 1'b1;
                    cx_d       = 8'd0;
                    cy_d       = 7'd0;
                    state_d    = S_CLEAR;
                end else if (step && ready_q) begin
                    if (!((len_q > LW'(1)) && (dir == ~dir_q)))
                        dir_d = dir;
                    grow_d  = grow && (len_q < LW'(MAX_LEN));
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    state_d = S_CHECK;
                end
            end
            S_CLEAR: begin
                if (cx_q == 8'(XSCREEN - 1)) begin
                    cx_d = 8'd0;
                    if (cy_q == 7'(YSCREEN - 1)) begin
                        cy_d    = 7'd0;
                        idx_d   = '0;
                        state_d = S_DRAW_ALL;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_DRAW_ALL: begin
                cx_d = cell_cx_c;
                cy_d = cell_cy_c;
                if (cell_end_c) begin
                    if (LW'(idx_q) == len_q - LW'(1))
                        state_d = S_DONE;
                    else
                        idx_d = idx_q + IW'(1);
                end
            end
            S_CHECK: begin
                if (wall_c) begin
                    hit_wall_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    if (self_c)
                        hit_self_d = 1'b1;
                    state_d = grow_q ? S_SHIFT : S_ERASE_TAIL;
                end
            end
            S_ERASE_TAIL: begin
                cx_d = cell_cx_c;
                cy_d = cell_cy_c;
                if (cell_end_c)
                    state_d = S_SHIFT;
            end
            S_SHIFT: begin
                for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nh_x_c;
                seg_y_d[0] = nh_y_c;
                if (grow_q)
                    len_d = len_q + LW'(1);
                state_d = S_DRAW_HEAD;
            end
            S_DRAW_HEAD: begin
                cx_d = cell_cx_c;
                cy_d = cell_cy_c;
                if (cell_end_c)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pixel outputs are registered from the state being entered
        case (state_d)
            S_DRAW_ALL:   pix_idx_c = idx_d;
            S_ERASE_TAIL: pix_idx_c = IW'(len_d - LW'(1));
            default:      pix_idx_c = '0;
        endcase
        plot_d  = state_d inside {S_CLEAR, S_DRAW_ALL, S_ERASE_TAIL, S_DRAW_HEAD};
        erase_d = state_d inside {S_CLEAR, S_ERASE_TAIL};
        x_d     = (state_d == S_CLEAR) ? cx_d : seg_x_d[pix_idx_c] + cx_d;
        y_d     = (state_d == S_CLEAR) ? cy_d : seg_y_d[pix_idx_c] + cy_d;
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= (i == 0) ? 8'(X0) : 8'd0;
                seg_y_q[i] <= (i == 0) ? 7'(Y0) : 7'd0;
            end
            len_q      <= LW'(1);
            dir_q      <= D_RIGHT;
            grow_q     <= 1'b0;
            ready_q    <= 1'b0;
            cx_q       <= 8'd0;
            cy_q       <= 7'd0;
            idx_q      <= '0;
            hit_self_q <= 1'b0;
            hit_wall_q <= 1'b0;
            plot_q     <= 1'b0;
            erase_q    <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            grow_q     <= grow_d;
            ready_q    <= ready_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            idx_q      <= idx_d;
            hit_self_q <= hit_self_d;
            hit_wall_q <= hit_wall_d;
            plot_q     <= plot_d;
            erase_q    <= erase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign plot     = plot_q;
    assign x_out    = x_q;
    assign y_out    = y_q;
    assign erase    = erase_q;
    assign head_x   = seg_x_q[0];
    assign head_y   = seg_y_q[0];
    assign length   = len_q;
    assign hit_wall = hit_wall_q;
    assign hit_self = hit_self_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a random walk, each operation's
// pixel stream, latency and final state checked against a queue-based snake model.
module tb_snake_body_engine;

    localparam int CELL = 10;
    localparam int XS   = 160;
    localparam int YS   = 120;
    localparam int MAXL = 8;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          reset, init, step, grow;
    logic [1:0]    dir;
    logic          busy, done, plot, erase, hit_wall, hit_self;
    logic [7:0]    x_out, head_x;
    logic [6:0]    y_out, head_y;
    logic [LW-1:0] length;

    always #5 clk = ~clk;

    snake_body_engine dut (
        .clk(clk), .reset(reset), .init(init), .step(step), .dir(dir), .grow(grow),
        .busy(busy), .done(done), .plot(plot), .x_out(x_out), .y_out(y_out),
        .erase(erase), .head_x(head_x), .head_y(head_y), .length(length),
        .hit_wall(hit_wall), .hit_self(hit_self)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] cap[$];
    logic [15:0] exp_pix[$];
    int ndone, nwall;

    int mx[$];
    int my[$];
    int mdir;
    bit mself;
    bit mready;

    always @(negedge clk) begin
        if (plot) cap.push_back({erase, x_out, y_out});
        if (done) ndone++;
        if (hit_wall) nwall++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic add_cell(input int x, input int y, input bit e);
        for (int cy = 0; cy < CELL; cy++)
            for (int cx = 0; cx < CELL; cx++)
                exp_pix.push_back({e, 8'(x + cx), 7'(y + cy)});
    endtask

    function automatic bit is_wall(input int d);
        return (d == 3 && mx[0] == 0) || (d == 2 && my[0] == 0) ||
               (d == 0 && mx[0] == XS - CELL) || (d == 1 && my[0] == YS - CELL);
    endfunction

    task automatic model_init();
        mx = {80};
        my = {60};
        mdir = 0;
        mself = 0;
        mready = 1;
        exp_pix.delete();
        for (int y = 0; y < YS; y++)
            for (int x = 0; x < XS; x++)
                exp_pix.push_back({1'b1, 8'(x), 7'(y)});
        foreach (mx[i]) add_cell(mx[i], my[i], 1'b0);
    endtask

    task automatic model_step(input int d, input bit g, output int elat, output int ewall);
        int nx, ny, lim;
        bit eg;
        exp_pix.delete();
        ewall = 0;
        if (!(mx.size() > 1 && d == 3 - mdir)) mdir = d;
        if (is_wall(mdir)) begin
            elat = 2;
            ewall = 1;
            return;
        end
        nx = mx[0] + (mdir == 0 ? CELL : (mdir == 3 ? -CELL : 0));
        ny = my[0] + (mdir == 1 ? CELL : (mdir == 2 ? -CELL : 0));
        eg = g && (mx.size() < MAXL);
        lim = eg ? mx.size() : mx.size() - 1;
        for (int i = 0; i < lim; i++)
            if (mx[i] == nx && my[i] == ny) mself = 1;
        if (!eg) add_cell(mx[mx.size()-1], my[my.size()-1], 1'b1);
        mx.push_front(nx);
        my.push_front(ny);
        if (!eg) begin
            void'(mx.pop_back());
            void'(my.pop_back());
        end
        add_cell(nx, ny, 1'b0);
        elat = eg ? CELL * CELL + 3 : 2 * CELL * CELL + 3;
    endtask

    task automatic run_op(input bit is_init, input int d, input bit g, output int lat, output logic b1);
        @(negedge clk);
        cap.delete();
        ndone = 0;
        nwall = 0;
        init = is_init;
        step = ~is_init;
        dir  = 2'(d);
        grow = g;
        @(posedge clk);
        #1;
        init = 1'b0;
        step = 1'b0;
        grow = 1'b0;
        lat = -1;
        b1  = 1'b0;
        for (int c = 1; c <= 25000 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (done) lat = c;
        end
        @(negedge clk);
    endtask

    task automatic chk_result(input string tag);
        int mism = 0;
        int n;
        chk({tag, "/npix"}, cap.size(), exp_pix.size());
        n = (cap.size() < exp_pix.size()) ? cap.size() : exp_pix.size();
        for (int i = 0; i < n; i++)
            if (cap[i] !== exp_pix[i]) mism++;
        chk({tag, "/pixmism"}, mism, 0);
        chk({tag, "/ndone"}, ndone, 1);
        chk({tag, "/head_x"}, head_x, mx[0]);
        chk({tag, "/head_y"}, head_y, my[0]);
        chk({tag, "/length"}, length, mx.size());
        chk({tag, "/hit_self"}, hit_self, mself);
        chk({tag, "/busy_end"}, busy, 0);
    endtask

    task automatic do_init(input string tag);
        int lat;
        logic b1;
        model_init();
        run_op(1'b1, 0, 1'b0, lat, b1);
        chk({tag, "/lat"}, lat, XS * YS + mx.size() * CELL * CELL + 1);
        chk({tag, "/busy1"}, b1, 1);
        chk({tag, "/nwall"}, nwall, 0);
        chk_result(tag);
    endtask

    task automatic do_step(input string tag, input int d, input bit g);
        int lat, elat, ewall;
        logic b1;
        model_step(d, g, elat, ewall);
        run_op(1'b0, d, g, lat, b1);
        chk({tag, "/lat"}, lat, elat);
        chk({tag, "/busy1"}, b1, 1);
        chk({tag, "/nwall"}, nwall, ewall);
        chk_result(tag);
    endtask

    initial begin
        int d;
        reset = 1'b1;
        init  = 1'b0;
        step  = 1'b0;
        grow  = 1'b0;
        dir   = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst/plot", plot, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/hit_wall", hit_wall, 0);
        chk("rst/hit_self", hit_self, 0);
        chk("rst/length", length, 1);
        chk("rst/head_x", head_x, 80);
        chk("rst/head_y", head_y, 60);

        do_init("init1");

        do_step("s_right", 0, 1'b0);
        chk("s_right/hx90", head_x, 90);

        do_step("g1", 0, 1'b1);
        do_step("g2", 0, 1'b1);
        do_step("g3", 0, 1'b1);
        chk("grow3/len4", length, 4);
        do_step("rev", 3, 1'b0);
        chk("rev/hx130", head_x, 130);
        do_step("down", 1, 1'b0);
        chk("down/hy70", head_y, 70);
        do_step("r1", 0, 1'b0);
        do_step("up", 2, 1'b0);
        do_step("r2", 0, 1'b0);
        chk("atwall/hx150", head_x, 150);
        do_step("wall", 0, 1'b0);
        chk("wall/hx150", head_x, 150);

        do_init("init2");
        for (int i = 0; i < 4; i++) do_step("sg", 0, 1'b1);
        chk("sg/len5", length, 5);
        do_step("sd", 1, 1'b0);
        do_step("sl", 3, 1'b0);
        chk("sl/no_self", hit_self, 0);
        do_step("su", 2, 1'b0);
        chk("su/self", hit_self, 1);
        do_step("su2", 2, 1'b0);
        chk("su2/held", hit_self, 1);

        do_init("init3");
        chk("init3/self_clr", hit_self, 0);
        for (int i = 0; i < 4; i++) do_step("gr", 0, 1'b1);
        for (int i = 0; i < 4; i++) do_step("gd", 1, 1'b1);
        do_step("gl", 3, 1'b1);
        chk("sat/len8", length, 8);

        for (int i = 0; i < 30; i++)
            do_step("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Pick a legal, non-reversing move so the snake reaches its head redraw
        d = 0;
        for (int k = 3; k >= 0; k--)
            if (!(mx.size() > 1 && k == 3 - mdir) && !is_wall(k)) d = k;
        @(negedge clk);
        step = 1'b1;
        dir  = 2'(d);
        grow = 1'b0;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (150) @(negedge clk);
        chk("mid/plot", plot, 1);
        chk("mid/erase", erase, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst/plot", plot, 0);
        chk("mrst/busy", busy, 0);
        chk("mrst/done", done, 0);
        chk("mrst/head_x", head_x, 80);
        chk("mrst/head_y", head_y, 60);
        chk("mrst/length", length, 1);
        chk("mrst/hit_self", hit_self, 0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        cap.delete();
        ndone = 0;
        step = 1'b1;
        dir  = 2'd0;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (250) @(negedge clk);
        chk("noinit/npix", cap.size(), 0);
        chk("noinit/ndone", ndone, 0);
        chk("noinit/busy", busy, 0);
        chk("noinit/head_x", head_x, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
